// File: rtl/router_egress_queue.sv
// Four-way egress queue: each word in the din stream is buffered in the per-output FIFO
// selected by addr. Each output drains on its own valid/ready handshake. Words aimed at a
// full queue are dropped and counted in a saturating counter.
module router_egress_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_en,
    input  logic [1:0]            addr,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic [DATA_WIDTH-1:0] dout3,
    output logic                  dout_valid0,
    output logic                  dout_valid1,
    output logic                  dout_valid2,
    output logic                  dout_valid3,
    input  logic                  dout_ready0,
    input  logic                  dout_ready1,
    input  logic                  dout_ready2,
    input  logic                  dout_ready3,
    output logic [3:0]            full,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    // One extra bit so the count can hold DEPTH; empty/full come from the count alone.
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam ptr_t PtrOne  = ptr_t'(1);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam cnt_t CntFull = cnt_t'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DropOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [4][DEPTH];
    ptr_t                  rptr_q [4];
    ptr_t                  wptr_q [4];
    cnt_t                  count_q [4];
    logic [CNT_WIDTH-1:0]  drop_cnt_q;

    logic [3:0]            ready;
    logic [3:0]            valid;
    logic [3:0]            full_vec;
    logic [3:0]            push;
    logic [3:0]            pop;
    logic                  drop;
    logic [DATA_WIDTH-1:0] head [4];

    // Status, head data and push/pop/drop decisions, all from registered state.
    always_comb begin
        ready = {dout_ready3, dout_ready2, dout_ready1, dout_ready0};
        valid = '0;
        full_vec = '0;
        pop = '0;
        push = '0;
        drop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid[k]    = (count_q[k] != '0);
            full_vec[k] = (count_q[k] == CntFull);
            pop[k]      = valid[k] & ready[k];
            head[k]     = valid[k] ? mem_q[k][rptr_q[k]] : '0;
        end
        // A same-cycle pop does not free space: the drop decision sees registered full only.
        if (din_en) begin
            if (full_vec[addr]) begin
                drop = 1'b1;
            end else begin
                push[addr] = 1'b1;
            end
        end
    end

    // Pointer, occupancy and drop counter update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                rptr_q[k]  <= '0;
                wptr_q[k]  <= '0;
                count_q[k] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    wptr_q[k] <= wptr_q[k] + PtrOne;
                end
                if (pop[k]) begin
                    rptr_q[k] <= rptr_q[k] + PtrOne;
                end
                // Simultaneous push and pop leaves the count unchanged.
                if (push[k] && !pop[k]) begin
                    count_q[k] <= count_q[k] + CntOne;
                end else if (!push[k] && pop[k]) begin
                    count_q[k] <= count_q[k] - CntOne;
                end
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DropOne;
            end
        end
    end

    // Storage write; the RAM itself is never cleared.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset && push[k]) begin
                mem_q[k][wptr_q[k]] <= din;
            end
        end
    end

    assign dout0       = head[0];
    assign dout1       = head[1];
    assign dout2       = head[2];
    assign dout3       = head[3];
    assign dout_valid0 = valid[0];
    assign dout_valid1 = valid[1];
    assign dout_valid2 = valid[2];
    assign dout_valid3 = valid[3];
    assign full        = full_vec;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_router_egress_queue.sv
// Bench for router_egress_queue: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a queue-based model of the four FIFOs.
module tb_router_egress_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 2;
    localparam int          DMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_en;
    logic [1:0]    addr;
    logic [DW-1:0] dout [4];
    logic [3:0]    vld;
    logic [3:0]    rdy;
    logic [3:0]    full;
    logic [CW-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq [4][$];
    int            mdrop;

    router_egress_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_en     (din_en),
        .addr       (addr),
        .dout0      (dout[0]),
        .dout1      (dout[1]),
        .dout2      (dout[2]),
        .dout3      (dout[3]),
        .dout_valid0(vld[0]),
        .dout_valid1(vld[1]),
        .dout_valid2(vld[2]),
        .dout_valid3(vld[3]),
        .dout_ready0(rdy[0]),
        .dout_ready1(rdy[1]),
        .dout_ready2(rdy[2]),
        .dout_ready3(rdy[3]),
        .full       (full),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each edge does to the four FIFOs and the drop count.
    task automatic model_edge(input logic rst, input logic en, input logic [1:0] a,
                              input logic [DW-1:0] d, input logic [3:0] r);
        int sz [4];
        for (int k = 0; k < 4; k++) sz[k] = mq[k].size();
        if (rst) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            mdrop = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sz[k] > 0 && r[k]) void'(mq[k].pop_front());
            end
            if (en) begin
                if (sz[a] == DEPTH) begin
                    if (mdrop < DMAX) mdrop++;
                end else begin
                    mq[a].push_back(d);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] ev;
        logic [3:0] ef;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (mq[k].size() > 0);
            ef[k] = (mq[k].size() == DEPTH);
            chk($sformatf("dout%0d", k), 64'(dout[k]), ev[k] ? 64'(mq[k][0]) : 64'd0);
        end
        chk("dout_valid", 64'(vld), 64'(ev));
        chk("full", 64'(full), 64'(ef));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    endtask

    task automatic step(input logic rst, input logic en, input logic [1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] r);
        reset  = rst;
        din_en = en;
        addr   = a;
        din    = d;
        rdy    = r;
        @(posedge clk);
        model_edge(rst, en, a, d, r);
        #1;
        compare_all();
    endtask

    initial begin
        mdrop = 0;
        reset = 1'b1; din_en = 1'b0; addr = '0; din = '0; rdy = '0;

        // Reset then idle.
        step(1'b1, 1'b0, 2'd0, '0, 4'h0);
        step(1'b1, 1'b0, 2'd0, '0, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, '0, 4'h0);
        chk("idle_valid", 64'(vld), 64'h0);
        chk("idle_full", 64'(full), 64'h0);
        chk("idle_drop", 64'(drop_cnt), 64'h0);
        chk("idle_dout0", 64'(dout[0]), 64'h0);

        // Single push is visible one edge later, other ports untouched.
        step(1'b0, 1'b1, 2'd2, 32'hA5A5_0001, 4'h0);
        chk("q2_valid", 64'(vld), 64'b0100);
        chk("q2_head", 64'(dout[2]), 64'hA5A5_0001);
        chk("q2_other", 64'(dout[3]), 64'h0);
        step(1'b0, 1'b0, 2'd0, '0, 4'b0100);

        // Fill queue 1, overflow once, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd1, DW'(32'h10 + i), 4'h0);
        chk("q1_full", 64'(full), 64'b0010);
        chk("q1_drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("q1_drain", 64'(dout[1]), 64'(32'h10 + i));
            step(1'b0, 1'b0, 2'd0, '0, 4'b0010);
        end
        chk("q1_empty", 64'(vld[1]), 64'd0);

        // Full queue 0: a pop on the same cycle does not rescue the write.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, DW'(32'h20 + i), 4'h0);
        step(1'b0, 1'b1, 2'd0, 32'h24, 4'b0001);
        chk("q0_drop", 64'(drop_cnt), 64'd2);
        chk("q0_notfull", 64'(full), 64'h0);
        for (int i = 1; i < 4; i++) begin
            chk("q0_drain", 64'(dout[0]), 64'(32'h20 + i));
            step(1'b0, 1'b0, 2'd0, '0, 4'b0001);
        end
        chk("q0_empty", 64'(vld[0]), 64'd0);

        // Queue 3: simultaneous push and pop keeps order.
        step(1'b0, 1'b1, 2'd3, 32'h31, 4'h0);
        step(1'b0, 1'b1, 2'd3, 32'h32, 4'h0);
        step(1'b0, 1'b1, 2'd3, 32'h33, 4'b1000);
        chk("q3_head", 64'(dout[3]), 64'h32);
        step(1'b0, 1'b0, 2'd0, '0, 4'b1000);
        chk("q3_next", 64'(dout[3]), 64'h33);
        step(1'b0, 1'b0, 2'd0, '0, 4'b1000);
        chk("q3_empty", 64'(vld[3]), 64'd0);

        // Saturate the 2-bit drop counter with five more drops.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd2, DW'(32'h40 + i), 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, DW'(32'h50 + i), 4'h0);
        chk("drop_sat", 64'(drop_cnt), 64'd3);
        chk("q2_head_kept", 64'(dout[2]), 64'h40);

        // Reset mid-operation discards data; a write on the reset cycle is ignored.
        step(1'b0, 1'b1, 2'd1, 32'h61, 4'h0);
        step(1'b1, 1'b1, 2'd0, 32'h62, 4'h0);
        chk("rst_valid", 64'(vld), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_full", 64'(full), 64'h0);
        step(1'b0, 1'b0, 2'd0, '0, 4'h0);
        chk("rst_after", 64'(vld), 64'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic          rr;
            logic          en;
            logic [3:0]    rd;
            rr = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 3) != 0);
            rd = 4'($urandom) & 4'($urandom);
            step(rr, en, 2'($urandom), DW'($urandom), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
